// File: rtl/riscv_lsu_ram_port.sv
// riscv_lsu_ram_port
// Load/store unit in front of port A of the dual-port data RAM. It accepts one
// core request at a time and drives the RAM enable, write enable, byte enables,
// byte offset and lane-aligned store data. For loads it captures the RAM's
// registered read data and returns it extracted and sign- or zero-extended.
// Misaligned, illegal-size and out-of-range requests are answered with rsp_err
// and never reach the RAM.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   req_valid / req_ready    request handshake; ready only in IDLE
//   req_we, req_size,        store/load, 0=byte 1=half 2=word 3=illegal,
//   req_unsigned             zero-extend loads when set
//   req_addr, req_wdata      byte address, right-justified store data
//   rsp_valid / rsp_ready    response handshake
//   rsp_rdata, rsp_err       extended load data (0 for stores/errors), error flag
//   ram_en, ram_we, ram_be   RAM port A controls, asserted only in ACCESS
//   ram_addr, ram_wdata      byte offset from ADDR_BASE, lane-aligned store data
//   ram_rdata                RAM read data, valid the cycle after ram_en
module riscv_lsu_ram_port #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned RAMSZ     = 64,
  parameter logic [31:0] ADDR_BASE = 32'h0001_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [1:0]         req_size,
  input  logic               req_unsigned,
  input  logic [WIDTH-1:0]   req_addr,
  input  logic [WIDTH-1:0]   req_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_rdata,
  output logic               rsp_err,
  output logic               ram_en,
  output logic               ram_we,
  output logic [WIDTH/8-1:0] ram_be,
  output logic [WIDTH-1:0]   ram_addr,
  output logic [WIDTH-1:0]   ram_wdata,
  input  logic [WIDTH-1:0]   ram_rdata
);

  localparam logic [WIDTH-1:0] RamBytes = WIDTH'(RAMSZ * 1024);

  typedef enum logic [1:0] {StIdle, StAccess, StRdWait, StResp} state_e;

  state_e             state_q, state_d;
  logic [1:0]         lane_q, lane_d;
  logic [1:0]         size_q, size_d;
  logic               uns_q, uns_d;
  logic               we_q, we_d;
  logic               ram_en_q, ram_en_d;
  logic               ram_we_q, ram_we_d;
  logic [WIDTH/8-1:0] ram_be_q, ram_be_d;
  logic [WIDTH-1:0]   ram_addr_q, ram_addr_d;
  logic [WIDTH-1:0]   ram_wdata_q, ram_wdata_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;

  logic [WIDTH-1:0]   offset;
  logic               req_err;
  logic [WIDTH/8-1:0] st_be;
  logic [WIDTH-1:0]   st_wdata;
  logic [WIDTH-1:0]   ld_sh;
  logic [WIDTH-1:0]   ld_ext;

  // Unsigned subtraction: addresses below ADDR_BASE wrap to huge offsets and
  // fail the range check.
  assign offset = req_addr - ADDR_BASE;

  always_comb begin
    req_err = 1'b0;
    case (req_size)
      2'd0:    req_err = 1'b0;
      2'd1:    req_err = req_addr[0];
      2'd2:    req_err = |req_addr[1:0];
      default: req_err = 1'b1;
    endcase
    if (offset >= RamBytes) req_err = 1'b1;
  end

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = req_wdata;
    case (req_size)
      2'd0: begin
        st_be    = 4'b0001 << req_addr[1:0];
        st_wdata = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        st_be    = 4'b0011 << req_addr[1:0];
        st_wdata = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Word loads are always aligned, so lane_q is 0 and ld_sh equals ram_rdata.
  assign ld_sh = ram_rdata >> {lane_q, 3'b000};

  always_comb begin
    ld_ext = ld_sh;
    case (size_q)
      2'd0:    ld_ext = uns_q ? {24'b0, ld_sh[7:0]} : {{24{ld_sh[7]}}, ld_sh[7:0]};
      2'd1:    ld_ext = uns_q ? {16'b0, ld_sh[15:0]} : {{16{ld_sh[15]}}, ld_sh[15:0]};
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    size_d      = size_q;
    uns_d       = uns_q;
    we_d        = we_q;
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_be_d    = '0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          lane_d = req_addr[1:0];
          size_d = req_size;
          uns_d  = req_unsigned;
          we_d   = req_we;
          if (req_err) begin
            state_d     = StResp;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d    = StAccess;
            ram_en_d   = 1'b1;
            ram_we_d   = req_we;
            ram_be_d   = req_we ? st_be : '0;
            ram_addr_d = offset;
            if (req_we) ram_wdata_d = st_wdata;
          end
        end
      end
      StAccess: begin
        if (we_q) begin
          state_d     = StResp;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
        end else begin
          state_d = StRdWait;
        end
      end
      StRdWait: begin
        // RAM output is valid in this cycle.
        state_d     = StResp;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = ld_ext;
      end
      StResp: begin
        if (rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      lane_q      <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      we_q        <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_be_q    <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      we_q        <= we_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_be_q    <= ram_be_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_be    = ram_be_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_riscv_lsu_ram_port.sv
// Testbench for riscv_lsu_ram_port: table of request vectors with a small RAM
// model, a response scoreboard queue, plus hand-written backpressure and
// mid-operation reset sequences.
module tb_riscv_lsu_ram_port;

  localparam logic [31:0] Base = 32'h0001_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        ram_en, ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_addr, ram_wdata;
  logic [31:0] ram_rdata = '0;

  riscv_lsu_ram_port #(
    .WIDTH    (32),
    .RAMSZ    (64),
    .ADDR_BASE(Base)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .ram_en      (ram_en),
    .ram_we      (ram_we),
    .ram_be      (ram_be),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM model: 64 KiB, registered read, byte-enabled write.
  logic [31:0] mem [0:16383];
  initial begin
    mem[0]     <= 32'h8001_1234;
    mem[1]     <= 32'h0000_0000;
    mem[2]     <= 32'h0000_0000;
    mem[16383] <= 32'h0000_0000;
  end
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_be[b]) mem[ram_addr[15:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
      end else begin
        ram_rdata <= mem[ram_addr[15:2]];
      end
    end
  end

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] ram_wd;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[20];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(input string name, input logic we, input logic [1:0] size,
                              input logic uns, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic err,
                              input logic [31:0] rdata, input logic [3:0] be,
                              input logic [31:0] ram_wd);
    vec_t v;
    v.name = name; v.we = we; v.size = size; v.uns = uns; v.addr = addr;
    v.wdata = wdata; v.err = err; v.rdata = rdata; v.be = be; v.ram_wd = ram_wd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
  endtask

  task automatic scramble();
    req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
    req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
  endtask

  // Waits (bounded) for rsp_valid; counts cycles since accept and ram_en pulses.
  task automatic wait_rsp(input string name, input vec_t v, output bit seen, output int cyc,
                          output int en_cnt);
    seen = 0; cyc = 0; en_cnt = 0;
    while (!seen && cyc < 8) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        scramble();
        if (!v.err) begin
          chk({name, " ram_we"}, 32'(ram_we), 32'(v.we));
          chk({name, " ram_be"}, 32'(ram_be), v.we ? 32'(v.be) : 32'd0);
          chk({name, " ram_addr"}, ram_addr, v.addr - Base);
          if (v.we) chk({name, " ram_wdata"}, ram_wdata, v.ram_wd);
        end
      end
      en_cnt += int'(ram_en);
      if (rsp_valid) seen = 1;
    end
    if (!seen) chk({name, " rsp timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    bit   seen;
    int   cyc, en_cnt;
    rsp_ready = 1'b1;
    chk({v.name, " req_ready"}, 32'(req_ready), 32'd1);
    drive(v.we, v.size, v.uns, v.addr, v.wdata);
    e.err = v.err; e.rdata = v.rdata; e.lat = v.err ? 1 : (v.we ? 2 : 3);
    sb.push_back(e);
    wait_rsp(v.name, v, seen, cyc, en_cnt);
    e = sb.pop_front();
    if (seen) begin
      chk({v.name, " rsp_err"}, 32'(rsp_err), 32'(e.err));
      chk({v.name, " rsp_rdata"}, rsp_rdata, e.rdata);
      chk({v.name, " latency"}, 32'(cyc), 32'(e.lat));
    end
    chk({v.name, " ram_en pulses"}, 32'(en_cnt), v.err ? 32'd0 : 32'd1);
    @(negedge clk);
    chk({v.name, " rsp_valid clr"}, 32'(rsp_valid), 32'd0);
    chk({v.name, " ready again"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    bit   seen;
    int   cyc, en_cnt;
    vec_t v;

    vecs[0]  = mk("st_w",      1, 2, 0, 32'h0001_0008, 32'hDEAD_BEEF, 0, 32'h0,         4'hF, 32'hDEAD_BEEF);
    vecs[1]  = mk("ld_w",      0, 2, 0, 32'h0001_0008, 32'h0,         0, 32'hDEAD_BEEF, 4'h0, 32'h0);
    vecs[2]  = mk("ld_h_s",    0, 1, 0, 32'h0001_0002, 32'h0,         0, 32'hFFFF_8001, 4'h0, 32'h0);
    vecs[3]  = mk("ld_h_u",    0, 1, 1, 32'h0001_0002, 32'h0,         0, 32'h0000_8001, 4'h0, 32'h0);
    vecs[4]  = mk("ld_b_s1",   0, 0, 0, 32'h0001_0001, 32'h0,         0, 32'h0000_0012, 4'h0, 32'h0);
    vecs[5]  = mk("st_h6",     1, 1, 0, 32'h0001_0006, 32'h1234_ABCD, 0, 32'h0,         4'hC, 32'hABCD_ABCD);
    vecs[6]  = mk("ld_h6_s",   0, 1, 0, 32'h0001_0006, 32'h0,         0, 32'hFFFF_ABCD, 4'h0, 32'h0);
    vecs[7]  = mk("st_b3",     1, 0, 0, 32'h0001_0003, 32'h0000_00A5, 0, 32'h0,         4'h8, 32'hA5A5_A5A5);
    vecs[8]  = mk("ld_b3_s",   0, 0, 0, 32'h0001_0003, 32'h0,         0, 32'hFFFF_FFA5, 4'h0, 32'h0);
    vecs[9]  = mk("ld_b3_u",   0, 0, 1, 32'h0001_0003, 32'h0,         0, 32'h0000_00A5, 4'h0, 32'h0);
    vecs[10] = mk("st_b_top",  1, 0, 0, 32'h0001_FFFF, 32'h0000_007E, 0, 32'h0,         4'h8, 32'h7E7E_7E7E);
    vecs[11] = mk("ld_b_top",  0, 0, 1, 32'h0001_FFFF, 32'h0,         0, 32'h0000_007E, 4'h0, 32'h0);
    vecs[12] = mk("st_b1",     1, 0, 0, 32'h0001_0001, 32'hFFFF_FF5A, 0, 32'h0,         4'h2, 32'h5A5A_5A5A);
    vecs[13] = mk("ld_w0",     0, 2, 0, 32'h0001_0000, 32'h0,         0, 32'hA501_5A34, 4'h0, 32'h0);
    vecs[14] = mk("err_h_mis", 0, 1, 0, 32'h0001_0001, 32'h0,         1, 32'h0,         4'h0, 32'h0);
    vecs[15] = mk("err_w_mis", 1, 2, 0, 32'h0001_0006, 32'h1111_1111, 1, 32'h0,         4'h0, 32'h0);
    vecs[16] = mk("err_size3", 0, 3, 0, 32'h0001_0000, 32'h0,         1, 32'h0,         4'h0, 32'h0);
    vecs[17] = mk("err_range", 0, 2, 0, 32'h0002_0000, 32'h0,         1, 32'h0,         4'h0, 32'h0);
    vecs[18] = mk("err_wrap",  0, 2, 0, 32'h0000_FFFC, 32'h0,         1, 32'h0,         4'h0, 32'h0);
    vecs[19] = mk("err_st_rg", 1, 0, 0, 32'h0002_0000, 32'h0000_0033, 1, 32'h0,         4'h0, 32'h0);

    rst = 1'b1; rsp_ready = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst ram_en", 32'(ram_en), 32'd0);
    chk("rst ram_we", 32'(ram_we), 32'd0);
    chk("rst ram_be", 32'(ram_be), 32'd0);
    chk("rst ram_addr", ram_addr, 32'd0);
    chk("rst ram_wdata", ram_wdata, 32'd0);
    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst rsp_rdata", rsp_rdata, 32'd0);
    chk("rst rsp_err", 32'(rsp_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post-rst req_ready", 32'(req_ready), 32'd1);

    // Backpressure on a load; a store offered meanwhile must be ignored.
    v = mk("bp", 0, 1, 0, 32'h0001_0002, 32'h0, 0, 32'hFFFF_8001, 4'h0, 32'h0);
    rsp_ready = 1'b0;
    drive(v.we, v.size, v.uns, v.addr, v.wdata);
    e.err = 1'b0; e.rdata = v.rdata; e.lat = 3;
    sb.push_back(e);
    wait_rsp("bp", v, seen, cyc, en_cnt);
    e = sb.pop_front();
    if (seen) begin
      chk("bp rdata", rsp_rdata, e.rdata);
      chk("bp latency", 32'(cyc), 32'(e.lat));
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'd2, 1'b0, 32'h0001_0000, 32'h0BAD_F00D);
      @(negedge clk);
      chk("bp hold valid", 32'(rsp_valid), 32'd1);
      chk("bp hold rdata", rsp_rdata, 32'hFFFF_8001);
      chk("bp hold err", 32'(rsp_err), 32'd0);
      chk("bp hold ready", 32'(req_ready), 32'd0);
      chk("bp hold ram_en", 32'(ram_en), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp released valid", 32'(rsp_valid), 32'd0);
    chk("bp released ready", 32'(req_ready), 32'd1);
    chk("bp released rdata", rsp_rdata, 32'd0);
    run_vec(mk("bp ignored st", 0, 2, 0, 32'h0001_0000, 32'h0, 0, 32'h8001_1234, 4'h0, 32'h0));

    for (int i = 0; i < 20; i++) run_vec(vecs[i]);

    // Reset asserted during the ACCESS cycle of a load.
    rsp_ready = 1'b1;
    drive(1'b0, 2'd2, 1'b0, 32'h0001_0008, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("mid-rst access ram_en", 32'(ram_en), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("mid-rst ram_en async", 32'(ram_en), 32'd0);
    chk("mid-rst rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    en_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      en_cnt += int'(rsp_valid);
    end
    chk("mid-rst rsp never", 32'(en_cnt), 32'd0);
    chk("mid-rst req_ready", 32'(req_ready), 32'd1);
    run_vec(mk("post-rst ld_w", 0, 2, 0, 32'h0001_0008, 32'h0, 0, 32'hDEAD_BEEF, 4'h0, 32'h0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
